// File: rtl/median_pkg.sv
// Shared types for the median filter path: pixel width, RGB pixel struct
// and the window feeder state encoding.
package median_pkg;

  localparam int unsigned PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_pixel_t;

  typedef enum logic [1:0] {
    ACCEPT,
    ISSUE,
    WAIT
  } feeder_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of RGB pixels; asynchronous read, synchronous write at the
// same address so a column can be read and overwritten in one cycle.
module line_buffer
  import median_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  rgb_pixel_t               din,
  output rgb_pixel_t               dout
);

  rgb_pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/median_window_feeder.sv
// Raster pixel stream to 3x3 RGB windows, handing one window at a time to
// the median filter with a start/done handshake.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  output logic [PIX_W-1:0] win_r [0:2][0:2],
  output logic [PIX_W-1:0] win_g [0:2][0:2],
  output logic [PIX_W-1:0] win_b [0:2][0:2],
  output logic             start,
  input  logic             done,
  output logic             frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  feeder_state_t    state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_win;

  rgb_pixel_t pix_in;
  rgb_pixel_t lb1_q;
  rgb_pixel_t lb2_q;
  rgb_pixel_t sh    [0:2][0:2];
  rgb_pixel_t sh_nx [0:2][0:2];
  rgb_pixel_t win_q [0:2][0:2];

  logic xfer;
  logic col_last;
  logic row_last;
  logic win_hit;

  assign pix_in   = '{r: pix_r, g: pix_g, b: pix_b};
  assign xfer     = pix_valid && pix_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign win_hit  = xfer && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // lb1 holds row r-1; on each transfer its old entry cascades into lb2
  // (row r-2) while the incoming pixel replaces it.
  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .we   (xfer),
    .addr (col),
    .din  (pix_in),
    .dout (lb1_q)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk  (clk),
    .we   (xfer),
    .addr (col),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  always_comb begin
    sh_nx = sh;
    for (int unsigned i = 0; i < 3; i++) begin
      sh_nx[i][0] = sh[i][1];
      sh_nx[i][1] = sh[i][2];
    end
    sh_nx[0][2] = lb2_q;
    sh_nx[1][2] = lb1_q;
    sh_nx[2][2] = pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '{default: '0};
    end else if (xfer) begin
      sh <= sh_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCEPT;
      col        <= '0;
      row        <= '0;
      pix_ready  <= 1'b0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      last_win   <= 1'b0;
      win_q      <= '{default: '0};
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;

      if (xfer) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      case (state)
        ACCEPT: begin
          if (win_hit) begin
            // Latch the post-shift window so it already includes this pixel.
            state     <= ISSUE;
            pix_ready <= 1'b0;
            start     <= 1'b1;
            win_q     <= sh_nx;
            last_win  <= row_last && col_last;
          end else begin
            pix_ready <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            state      <= ACCEPT;
            pix_ready  <= 1'b1;
            frame_done <= last_win;
          end
        end
        default: begin
          state     <= ACCEPT;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        win_r[i][j] = win_q[i][j].r;
        win_g[i][j] = win_q[i][j].g;
        win_b[i][j] = win_q[i][j].b;
      end
    end
  end

endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>=3).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pix_valid  input  1  upstream pixel valid.
REQ-006 pix_ready  output  1  feeder accepts pixel; transfer when pix_valid && pix_ready.
REQ-007 pix_r / pix_g / pix_b  input  8 each  raster-order RGB pixel.
REQ-008 win_r / win_g / win_b  output  8 each, unpacked [0:2][0:2]  3x3 window to median_filter; [row][col], [0][0] top-left.
REQ-009 start  output  1  one-cycle pulse to median_filter: window valid.
REQ-010 done  input  1  median_filter completion; sampled level, rising edge not required.
REQ-011 frame_done  output  1  one-cycle pulse after the last window of a frame completes.

Function
REQ-012 Pixels SHALL be accepted in raster order; col counts 0..IMG_W-1, row counts 0..IMG_H-1; both wrap to 0 after the last pixel of a frame.
REQ-013 Two line buffers of IMG_W 24-bit entries SHALL hold rows r-1 and r-2; a 3x3 register shift window per channel SHALL advance on every accepted pixel.
REQ-014 A window SHALL be complete when the accepted pixel has row>=2 and col>=2; its centre is (row-1, col-1). Border pixels SHALL produce no window.
REQ-015 Windows per frame SHALL equal (IMG_W-2)*(IMG_H-2); windows SHALL NOT span a row wrap.
REQ-016 FSM states: ACCEPT, ISSUE, WAIT.
REQ-017 ACCEPT: pix_ready=1; a transfer completing a window -> ISSUE; otherwise remain.
REQ-018 ISSUE: pix_ready=0, start=1 for exactly this cycle, win_* latched and stable -> WAIT.
REQ-019 WAIT: pix_ready=0, start=0, win_* held; done=1 -> ACCEPT (pix_ready=1 the following cycle).
REQ-020 Latency: start SHALL assert in the cycle immediately after the completing transfer.
REQ-021 win_* SHALL remain unchanged from ISSUE until WAIT exits.
REQ-022 done in ACCEPT or ISSUE SHALL be ignored (no state change, no window lost).
REQ-023 frame_done SHALL pulse in the cycle WAIT exits for the final window of a frame (row IMG_H-1, col IMG_W-1 transfer).
REQ-024 No pixel SHALL be dropped or duplicated under any pix_valid pattern; pix_valid while pix_ready=0 SHALL have no effect.

Reset
REQ-025 rst SHALL force: state=ACCEPT, row=col=0, pix_ready=0 while asserted then 1 in the first cycle after release, start=0, frame_done=0, win_*=0.
REQ-026 Line-buffer contents need not be cleared; the row counter guarantees stale data is never issued.
REQ-027 rst mid-frame or in WAIT SHALL abandon the frame; the next accepted pixel is (0,0).

Structure
REQ-028 Package median_pkg SHALL hold PIX_W=8, an rgb_pixel_t struct {r,g,b}, and the feeder state enum; median_filter SHALL reuse PIX_W.
REQ-029 One sub-module line_buffer (parameter DEPTH, rgb_pixel_t in/out, write-enable) SHALL be instantiated twice.

Verification
REQ-030 IMG_W=IMG_H=3, pixels R row0={2,30,23} row1={34,34,123} row2={23,33,34} (G, B likewise) -> exactly one start, after the 9th transfer; win_r equals the input array; frame_done after done.
REQ-031 IMG_W=IMG_H=4, pixel value = row*4+col on all channels, done returned 1 cycle after start -> 4 starts; centres 5,6,9,10; win_r[0][0] = 0,1,4,5.
REQ-032 IMG_W=IMG_H=4, done delayed 10 cycles, pix_valid held high -> pix_ready=0 for the whole of ISSUE+WAIT; all 16 pixels accepted exactly once.
REQ-033 done pulsed while in ACCEPT with no outstanding window -> no state change; next window is issued normally.
REQ-034 rst asserted in WAIT during frame 1, then a full 4x4 frame -> exactly 4 starts, windows match the fresh frame only.
REQ-035 Random pix_valid gaps (50% duty), 8x8 ramp -> 36 starts; every window matches the reference model; one frame_done.
